// File: rtl/mlram_pkg.sv
// Shared types and helpers for the multi-lane register-file RAM.
package mlram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Entry address of lane 'lane' for a beat based at 'base', wrapped to aw bits.
  function automatic int unsigned lane_addr(input int unsigned base,
                                            input int unsigned lane,
                                            input int unsigned aw);
    return (base + lane) & ((32'd1 << aw) - 32'd1);
  endfunction

  // Even parity (XOR reduction); callers zero-extend narrower words.
  function automatic logic parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mlram_init_sweep.sv
// Post-reset clear sweep: steps through every entry once, then holds init_done.
module mlram_init_sweep
  import mlram_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_done_o,
  output logic          sweep_we_c_o,
  output logic [AW-1:0] sweep_addr_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin : outputs
    sweep_we_c_o = (state_q == INIT);
    init_done_d  = (state_d == READY);
  end

  assign init_done_o  = init_done_q;
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/multi_lane_ram.sv
// Multi-lane write / single-entry read register-file RAM with write-first forwarding.
// Optional MLRAM_PARITY_EN adds per-entry even parity, rd_perr and inj_perr.
module multi_lane_ram
  import mlram_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned LANES = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [LANES-1:0]    wr_strb,
  input  logic [AW-1:0]       waddr,
  input  logic [LANES*DW-1:0] wdata,
  input  logic                rd_en,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       rdata,
  output logic                rd_valid
`ifdef MLRAM_PARITY_EN
  ,
  output logic                rd_perr,
  input  logic                inj_perr
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
`ifdef MLRAM_PARITY_EN
  localparam int unsigned EW = DW + 1;
`else
  localparam int unsigned EW = DW;
`endif

  logic [EW-1:0]             mem_q [DEPTH];
  logic                      sweep_we_c;
  logic [AW-1:0]             sweep_addr;
  logic [LANES-1:0]          lane_we_c;
  logic [LANES-1:0][AW-1:0]  lane_addr_c;
  logic [LANES-1:0][EW-1:0]  lane_word_c;
  logic [EW-1:0]             rd_word_c;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic                      rd_valid_q, rd_valid_d;

  mlram_init_sweep #(.AW(AW)) u_sweep (
    .clk          (clk),
    .rst          (rst),
    .init_done_o  (init_done),
    .sweep_we_c_o (sweep_we_c),
    .sweep_addr_o (sweep_addr)
  );

  // User writes only take effect once the sweep has finished.
  always_comb begin : lane_decode
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_addr_c[i] = AW'(lane_addr(32'(waddr), i, AW));
      lane_we_c[i]   = init_done & wr_en & wr_strb[i];
`ifdef MLRAM_PARITY_EN
      lane_word_c[i] = {parity(64'(wdata[i*DW +: DW])) ^ inj_perr, wdata[i*DW +: DW]};
`else
      lane_word_c[i] = wdata[i*DW +: DW];
`endif
    end
  end

  always_ff @(posedge clk) begin : mem_write
    if (sweep_we_c) begin
      mem_q[sweep_addr] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_we_c[i]) mem_q[lane_addr_c[i]] <= lane_word_c[i];
      end
    end
  end

  // Write-first: a same-cycle strobed lane hitting raddr overrides the array.
  always_comb begin : rd_forward
    rd_word_c = mem_q[raddr];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_we_c[i] && (lane_addr_c[i] == raddr)) rd_word_c = lane_word_c[i];
    end
  end

  always_comb begin : rd_next
    rd_valid_d = rd_en & init_done;
    rdata_d    = rd_valid_d ? rd_word_c[DW-1:0] : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin : rd_reg
    if (rst) begin
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef MLRAM_PARITY_EN
  logic rd_perr_q, rd_perr_d;

  always_comb begin : perr_next
    rd_perr_d = rd_valid_d & (parity(64'(rd_word_c[DW-1:0])) != rd_word_c[DW]);
  end

  always_ff @(posedge clk or posedge rst) begin : perr_reg
    if (rst) rd_perr_q <= 1'b0;
    else     rd_perr_q <= rd_perr_d;
  end

  assign rd_perr = rd_perr_q;
`endif

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_multi_lane_ram.sv
// Scoreboard bench for multi_lane_ram: array reference model, queued expectations, negedge monitor.
module tb_multi_lane_ram;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                init_done;
  logic                wr_en;
  logic [LANES-1:0]    wr_strb;
  logic [AW-1:0]       waddr;
  logic [LANES*DW-1:0] wdata;
  logic                rd_en;
  logic [AW-1:0]       raddr;
  logic [DW-1:0]       rdata;
  logic                rd_valid;
`ifdef MLRAM_PARITY_EN
  logic                rd_perr;
  logic                inj_perr;
`endif

  multi_lane_ram #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .wr_en     (wr_en),
    .wr_strb   (wr_strb),
    .waddr     (waddr),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .rd_valid  (rd_valid)
`ifdef MLRAM_PARITY_EN
    ,
    .rd_perr   (rd_perr),
    .inj_perr  (inj_perr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays of entry values and "stored with bad parity" flags.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_bad [DEPTH];
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] hold_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("rdata", 32'(rdata), 32'(e[DW-1:0]));
`ifdef MLRAM_PARITY_EN
          check("rd_perr", 32'(rd_perr), 32'(e[DW]));
`endif
          hold_val = e[DW-1:0];
        end
      end else begin
        check("rdata_hold", 32'(rdata), 32'(hold_val));
      end
    end
  end

  task automatic idle();
    wr_en = 1'b0; wr_strb = '0; waddr = '0; wdata = '0; rd_en = 1'b0; raddr = '0;
`ifdef MLRAM_PARITY_EN
    inj_perr = 1'b0;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
  endtask

  // Issue one beat (caller sits just after a rising edge); model applies write before read.
  task automatic step(input bit we, input logic [LANES-1:0] st, input int wa,
                      input logic [LANES*DW-1:0] wd, input bit re, input int ra, input bit inj);
    wr_en = we; wr_strb = st; waddr = AW'(wa); wdata = wd; rd_en = re; raddr = AW'(ra);
`ifdef MLRAM_PARITY_EN
    inj_perr = inj;
`endif
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (st[i]) begin
          int a;
          a = (wa + i) % int'(DEPTH);
          ref_mem[a] = wd[i*DW +: DW];
          ref_bad[a] = inj;
        end
      end
    end
    if (re) exp_q.push_back({ref_bad[ra], ref_mem[ra]});
    @(posedge clk); #1;
    idle();
  endtask

  // Counts rising edges from reset release until init_done rises, with junk traffic meanwhile.
  task automatic count_init(input int stop_at, output int n_edges);
    n_edges = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      n_edges = n;
      if (init_done || (n == stop_at)) break;
      wr_en = 1'(($urandom % 2)); wr_strb = LANES'($urandom); waddr = AW'($urandom);
      wdata = LANES*DW'($urandom); rd_en = 1'(($urandom % 2)); raddr = AW'($urandom);
    end
    idle();
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < int'(DEPTH); a++) step(1'b0, '0, 0, '0, 1'b1, a, 1'b0);
  endtask

  initial begin
    int n_edges;
    rst = 1'b1;
    idle();
    model_clear();
    #12;
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);

    @(negedge clk); rst = 1'b0;
    count_init(0, n_edges);
    check("init_cycles", 32'(n_edges), 32'd16);
    check("init_done_high", 32'(init_done), 32'd1);
    read_all_zero();

    // Two-lane write, upper-lane-only write, wrap-around, strobe-zero no-op.
    step(1'b1, 2'b11, 3, 32'hBEEF_1234, 1'b0, 0, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 3, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 4, 1'b0);
    step(1'b1, 2'b10, 7, 32'hCAFE_7777, 1'b0, 0, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 7, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 8, 1'b0);
    step(1'b1, 2'b11, 15, 32'hAAAA_5555, 1'b0, 0, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 15, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 0, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 1, 1'b0);
    step(1'b1, 2'b00, 9, 32'hFFFF_FFFF, 1'b1, 9, 1'b0);

    // Write-first collision on the upper lane.
    step(1'b1, 2'b01, 5, 32'h0000_1111, 1'b0, 0, 1'b0);
    step(1'b1, 2'b11, 4, 32'h2222_3333, 1'b1, 5, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 4, 1'b0);

    // Parity injection then clean rewrite (flags only compared with the parity build).
    step(1'b1, 2'b01, 2, 32'h0000_00FF, 1'b0, 0, 1'b1);
    step(1'b0, 2'b00, 0, '0, 1'b1, 2, 1'b0);
    step(1'b1, 2'b01, 2, 32'h0000_00FF, 1'b0, 0, 1'b0);
    step(1'b0, 2'b00, 0, '0, 1'b1, 2, 1'b0);

    for (int k = 0; k < 400; k++) begin
      step(1'((($urandom % 2))), LANES'($urandom), int'($urandom % DEPTH), LANES*DW'($urandom),
           ($urandom % 10) < 7, int'($urandom % DEPTH), ($urandom % 4) == 0);
    end

    // Read in flight when reset hits must be dropped.
    repeat (3) @(posedge clk);
    #1;
    check("drain_before_reset", 32'(exp_q.size()), 32'd0);
    rd_en = 1'b1; raddr = 4'd3;
    #1 rst = 1'b1;
    exp_q.delete();
    hold_val = '0;
    idle();
    #1;
    check("midrun_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrun_rst_rdata", 32'(rdata), 32'd0);
    check("midrun_rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset again eight edges into the sweep; the full sweep restarts from release.
    count_init(8, n_edges);
    check("partial_sweep_edges", 32'(n_edges), 32'd8);
    rst = 1'b1;
    #1;
    check("midsweep_init_done", 32'(init_done), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    count_init(0, n_edges);
    check("restart_init_cycles", 32'(n_edges), 32'd16);
    model_clear();
    read_all_zero();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
